// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the opcode encoding, the FSM state encoding and the operand payload struct.
package alu_arbiter_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_OP_W   = 4;

  localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] OP_MAX  = OP_SLTU;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0]   op;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and the ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [ALU_OP_W-1:0]   req_op0;
  logic [ALU_OP_W-1:0]   req_op1;
  logic [ALU_DATA_W-1:0] req_a0;
  logic [ALU_DATA_W-1:0] req_b0;
  logic [ALU_DATA_W-1:0] req_a1;
  logic [ALU_DATA_W-1:0] req_b1;
  logic [1:0]            resp_valid;
  logic [1:0]            resp_ready;
  logic [ALU_DATA_W-1:0] resp_data;
  logic                  resp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: ten legal opcodes, anything above OP_MAX yields zero and flags an error.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  alu_req_t              req,
  output logic [ALU_DATA_W-1:0] y_c,
  output logic                  err_c
);

  logic [4:0] shamt_c;
  assign shamt_c = req.b[4:0];

  always_comb begin
    y_c = '0;
    case (req.op)
      OP_ADD:  y_c = req.a + req.b;
      OP_SUB:  y_c = req.a - req.b;
      OP_AND:  y_c = req.a & req.b;
      OP_OR:   y_c = req.a | req.b;
      OP_XOR:  y_c = req.a ^ req.b;
      OP_SLL:  y_c = req.a << shamt_c;
      OP_SRL:  y_c = req.a >> shamt_c;
      OP_SRA:  y_c = ALU_DATA_W'($signed(req.a) >>> shamt_c);
      OP_SLT:  y_c = ALU_DATA_W'($signed(req.a) < $signed(req.b));
      OP_SLTU: y_c = ALU_DATA_W'(req.a < req.b);
      default: y_c = '0;
    endcase
  end

  assign err_c = (req.op > OP_MAX);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// IDLE accepts one request, EXEC registers the ALU result, RESP holds it until the winner consumes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned OP_W   = ALU_OP_W
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  state_e              state_q;
  logic                prio_q;
  logic                win_q;
  alu_req_t            opnd_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                resp_err_q;
  logic [1:0]          resp_valid_q;

  logic                gnt_c;
  logic [1:0]          ready_c;
  logic                accept_c;
  logic [OP_W-1:0]     sel_op_c;
  logic [DATA_W-1:0]   sel_a_c;
  logic [DATA_W-1:0]   sel_b_c;
  logic [DATA_W-1:0]   alu_y_c;
  logic                alu_err_c;

  // Grant: a lone requester wins outright, a tie goes to the priority pointer.
  always_comb begin
    gnt_c = prio_q;
    if (bus.req_valid == 2'b01) begin
      gnt_c = 1'b0;
    end else if (bus.req_valid == 2'b10) begin
      gnt_c = 1'b1;
    end
    ready_c = 2'b00;
    if (rst_n && (state_q == ST_IDLE) && (|bus.req_valid)) begin
      ready_c = gnt_c ? 2'b10 : 2'b01;
    end
    sel_op_c = gnt_c ? bus.req_op1 : bus.req_op0;
    sel_a_c  = gnt_c ? bus.req_a1  : bus.req_a0;
    sel_b_c  = gnt_c ? bus.req_b1  : bus.req_b0;
  end

  assign accept_c = |(bus.req_valid & ready_c);

  alu_arbiter_alu u_alu (
    .req   (opnd_q),
    .y_c   (alu_y_c),
    .err_c (alu_err_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      win_q        <= 1'b0;
      opnd_q       <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 2'b00;
      busy         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            opnd_q  <= '{op: sel_op_c, a: sel_a_c, b: sel_b_c};
            win_q   <= gnt_c;
            prio_q  <= ~gnt_c;
            state_q <= ST_EXEC;
            busy    <= 1'b1;
          end
        end
        ST_EXEC: begin
          resp_data_q  <= alu_y_c;
          resp_err_q   <= alu_err_c;
          resp_valid_q <= win_q ? 2'b10 : 2'b01;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          // Only the winner's resp_ready can complete the handshake.
          if (|(resp_valid_q & bus.resp_ready)) begin
            resp_valid_q <= 2'b00;
            state_q      <= ST_IDLE;
            busy         <= 1'b0;
          end
        end
        default: begin
          resp_valid_q <= 2'b00;
          state_q      <= ST_IDLE;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  logic busy;

  alu_arbiter_if bus ();

  alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int tests = 0;
  int fails = 0;

  bit          exp_prio;
  logic [3:0]  pop [2];
  logic [31:0] pa  [2];
  logic [31:0] pb  [2];

  int          waitc;
  int          lat;
  logic        win;
  logic        err;
  logic        ok;
  logic        stable;
  logic        excl;
  logic        idle;
  logic [31:0] data;
  logic [32:0] exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required normal finish");
    $fatal(1, "watchdog");
  end

  // Reference: {err, result} from the opcode table with plain arithmetic.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0: return {1'b0, a + b};
      4'd1: return {1'b0, a - b};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: return {1'b0, a << sh};
      4'd6: return {1'b0, a >> sh};
      4'd7: begin
        ext = {{32{a[31]}}, a};
        ext = ext >> sh;
        return {1'b0, ext[31:0]};
      end
      4'd8: return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      4'd9: return {1'b0, 31'd0, (a < b)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic drive_payloads();
    bus.req_op0 = pop[0]; bus.req_a0 = pa[0]; bus.req_b0 = pb[0];
    bus.req_op1 = pop[1]; bus.req_a1 = pa[1]; bus.req_b1 = pb[1];
  endtask

  task automatic rand_payload(input int r, input int unsigned max_op);
    pop[r] = 4'($urandom_range(0, max_op));
    pa[r]  = $urandom;
    pb[r]  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
  endtask

  // Observer: waits for an accept, follows the transaction to its handshake and records what it saw.
  task automatic run_txn(input int hold, input bit drop);
    ok = 0; stable = 1; excl = 1; idle = 0; win = 0; lat = 0; data = '0; err = 0; waitc = 0;
    #1;
    while (waitc < 20 && !(|(bus.req_valid & bus.req_ready))) begin
      if ($countones(bus.req_ready) > 1) excl = 0;
      @(negedge clk); #1; waitc++;
    end
    if (!(|(bus.req_valid & bus.req_ready))) return;
    if ($countones(bus.req_ready) > 1) excl = 0;
    win = bus.req_ready[1];
    @(negedge clk);
    lat = 1;
    if (drop) begin
      if (win) bus.req_valid[1] = 1'b0;
      else     bus.req_valid[0] = 1'b0;
    end
    while (bus.resp_valid == 2'b00 && lat < 10) begin
      if (bus.req_ready != 2'b00 || busy !== 1'b1) stable = 0;
      @(negedge clk); lat++;
    end
    if (bus.resp_valid == 2'b00) return;
    ok = 1; data = bus.resp_data; err = bus.resp_err;
    if (bus.resp_valid !== (win ? 2'b10 : 2'b01)) excl = 0;
    bus.resp_ready = win ? 2'b01 : 2'b10;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus.resp_valid !== (win ? 2'b10 : 2'b01) || bus.resp_data !== data ||
          bus.resp_err !== err || busy !== 1'b1 || bus.req_ready !== 2'b00) stable = 0;
    end
    bus.resp_ready = win ? 2'b10 : 2'b01;
    @(negedge clk);
    bus.resp_ready = 2'b00;
    idle = (busy === 1'b0) && (bus.resp_valid === 2'b00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    @(negedge clk); #1;
    tests++; if (bus.resp_valid !== 2'b00) begin fails++; $display("FAIL reset_resp_valid: got %b, required 00", bus.resp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++; if (bus.resp_data !== 32'd0 || bus.resp_err !== 1'b0) begin fails++; $display("FAIL reset_data: got %h/%b, required 0/0", bus.resp_data, bus.resp_err); end
    tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b, required 00", bus.req_ready); end
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    exp_prio = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    pop[0] = 4'd0; pa[0] = 32'd5; pb[0] = 32'd7; drive_payloads();
    bus.req_valid = 2'b01; #1;
    tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL single_ready: got %b, required 01", bus.req_ready); end
    run_txn(0, 1);
    tests++; if (ok !== 1'b1 || win !== 1'b0) begin fails++; $display("FAIL single_grant: got ok=%b win=%b, required 1/0", ok, win); end
    tests++; if (lat != 2) begin fails++; $display("FAIL single_latency: got %0d, required 2", lat); end
    tests++; if (data !== 32'd12 || err !== 1'b0) begin fails++; $display("FAIL single_data: got %0d/%b, required 12/0", data, err); end
    tests++; if (stable !== 1'b1 || idle !== 1'b1) begin fails++; $display("FAIL single_flow: got stable=%b idle=%b, required 1/1", stable, idle); end
    exp_prio = 1;
  endtask

  task automatic test_both_from_reset();
    rst_n = 1'b0;
    pop[0] = 4'd1; pa[0] = 32'd10;         pb[0] = 32'd3;
    pop[1] = 4'd7; pa[1] = 32'h8000_0000;  pb[1] = 32'd4;
    drive_payloads();
    bus.req_valid = 2'b11;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_prio = 0;
    run_txn(0, 0);
    tests++; if (waitc != 0) begin fails++; $display("FAIL both_first_accept: got wait %0d, required 0", waitc); end
    tests++; if (win !== 1'b0 || data !== 32'd7) begin fails++; $display("FAIL both_first: got win=%b data=%h, required 0/7", win, data); end
    run_txn(0, 1);
    tests++; if (win !== 1'b1 || data !== 32'hF800_0000 || lat != 2) begin fails++; $display("FAIL both_second: got win=%b data=%h lat=%0d, required 1/f8000000/2", win, data, lat); end
    bus.req_valid = 2'b00;
    exp_prio = 0;
  endtask

  task automatic test_alternate();
    logic exp_w;
    rand_payload(0, 9); rand_payload(1, 9); drive_payloads();
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_w = exp_prio;
      exp = ref_alu(pop[exp_w], pa[exp_w], pb[exp_w]);
      run_txn(0, 0);
      tests++; if (win !== exp_w) begin fails++; $display("FAIL alt_grant%0d: got %b, required %b", k, win, exp_w); end
      tests++; if (data !== exp[31:0] || err !== exp[32]) begin fails++; $display("FAIL alt_data%0d: got %h/%b, required %h/%b", k, data, err, exp[31:0], exp[32]); end
      tests++; if (excl !== 1'b1 || lat != 2 || idle !== 1'b1) begin fails++; $display("FAIL alt_flow%0d: got excl=%b lat=%0d idle=%b, required 1/2/1", k, excl, lat, idle); end
      exp_prio = ~exp_w;
      rand_payload(int'(win), 9); drive_payloads();
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_stall();
    pop[1] = 4'd1; pa[1] = $urandom; pb[1] = $urandom; drive_payloads();
    exp = ref_alu(pop[1], pa[1], pb[1]);
    bus.req_valid = 2'b10;
    run_txn(5, 1);
    tests++; if (stable !== 1'b1) begin fails++; $display("FAIL stall_stable: got %b, required 1", stable); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL stall_idle: got %b, required 1", idle); end
    tests++; if (win !== 1'b1 || data !== exp[31:0]) begin fails++; $display("FAIL stall_data: got win=%b data=%h, required 1/%h", win, data, exp[31:0]); end
    exp_prio = 0;
  endtask

  task automatic test_illegal();
    pop[0] = 4'd12; pa[0] = 32'd1; pb[0] = 32'd1; drive_payloads();
    bus.req_valid = 2'b01;
    run_txn(1, 1);
    tests++; if (data !== 32'd0 || err !== 1'b1) begin fails++; $display("FAIL illegal_12: got %h/%b, required 0/1", data, err); end
    exp_prio = 1;
    pop[1] = 4'($urandom_range(10, 15)); pa[1] = $urandom; pb[1] = $urandom; drive_payloads();
    bus.req_valid = 2'b10;
    run_txn(0, 1);
    tests++; if (data !== 32'd0 || err !== 1'b1 || idle !== 1'b1) begin fails++; $display("FAIL illegal_rand: got %h/%b idle=%b, required 0/1/1", data, err, idle); end
    exp_prio = 0;
    bus.req_valid = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0] pat;
    logic       exp_w;
    for (int k = 0; k < 20; k++) begin
      rand_payload(0, 15); rand_payload(1, 15); drive_payloads();
      pat = 2'($urandom_range(1, 3));
      exp_w = (pat == 2'b11) ? exp_prio : pat[1];
      exp = ref_alu(pop[exp_w], pa[exp_w], pb[exp_w]);
      bus.req_valid = pat;
      run_txn(int'($urandom_range(0, 3)), 1);
      tests++; if (ok !== 1'b1 || win !== exp_w) begin fails++; $display("FAIL rand_grant%0d: got ok=%b win=%b, required 1/%b", k, ok, win, exp_w); end
      tests++; if (data !== exp[31:0] || err !== exp[32]) begin fails++; $display("FAIL rand_data%0d: op %0d got %h/%b, required %h/%b", k, pop[exp_w], data, err, exp[31:0], exp[32]); end
      tests++; if (lat != 2 || stable !== 1'b1 || excl !== 1'b1 || idle !== 1'b1) begin fails++; $display("FAIL rand_flow%0d: got lat=%0d stable=%b excl=%b idle=%b, required 2/1/1/1", k, lat, stable, excl, idle); end
      exp_prio = ~exp_w;
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_reset_in_exec();
    @(negedge clk);
    pop[1] = 4'd0; pa[1] = 32'd100; pb[1] = 32'd23; drive_payloads();
    bus.req_valid = 2'b10;
    run_txn(0, 1);
    tests++; if (data !== 32'd123) begin fails++; $display("FAIL rst_pre_data: got %0d, required 123", data); end
    pop[0] = 4'd0; pa[0] = 32'd1; pb[0] = 32'd2; drive_payloads();
    bus.req_valid = 2'b01;
    @(posedge clk); #2;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_pre_busy: got %b, required 1", busy); end
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin fails++; $display("FAIL rst_async_ctrl: got busy=%b rv=%b rr=%b, required 0/00/00", busy, bus.resp_valid, bus.req_ready); end
    tests++; if (bus.resp_data !== 32'd0 || bus.resp_err !== 1'b0) begin fails++; $display("FAIL rst_async_data: got %h/%b, required 0/0", bus.resp_data, bus.resp_err); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    exp_prio = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++; if (bus.resp_valid !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL rst_no_resp%0d: got rv=%b busy=%b, required 00/0", c, bus.resp_valid, busy); end
    end
    rand_payload(0, 9); rand_payload(1, 9); drive_payloads();
    exp = ref_alu(pop[0], pa[0], pb[0]);
    bus.req_valid = 2'b11; #1;
    tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL rst_next_grant: got %b, required 01", bus.req_ready); end
    run_txn(0, 1);
    tests++; if (win !== 1'b0 || data !== exp[31:0]) begin fails++; $display("FAIL rst_next_txn: got win=%b data=%h, required 0/%h", win, data, exp[31:0]); end
    bus.req_valid = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 2'b00; bus.resp_ready = 2'b00;
    bus.req_op0 = '0; bus.req_a0 = '0; bus.req_b0 = '0;
    bus.req_op1 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    test_reset();
    test_single();
    test_both_from_reset();
    test_alternate();
    test_stall();
    test_illegal();
    test_random();
    test_reset_in_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Parameter: OP_W, 4, opcode width, matching the ALU control encoding.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous and active-low.
REQ-005 Port: req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-006 Port: req_ready  output  2  per-requester accept; at most one bit set.
REQ-007 Port: req_op0 / req_op1  input  OP_W  opcode per requester.
REQ-008 Port: req_a0, req_b0, req_a1, req_b1  input  DATA_W  operands per requester.
REQ-009 Port: resp_valid  output  2  result valid for requester i; at most one bit set.
REQ-010 Port: resp_ready  input  2  requester i consumes result.
REQ-011 Port: resp_data  output  DATA_W  result, shared by both requesters, qualified by resp_valid.
REQ-012 Port: resp_err  output  1  opcode was outside 0-9; qualified by resp_valid.
REQ-013 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-015 IDLE: req_ready is driven combinationally to the granted requester only; both bits are 0 in EXEC and RESP.
REQ-016 Grant: if exactly one req_valid bit is set, that requester wins; if both are set, the requester indicated by the priority pointer wins.
REQ-017 Priority pointer: after each accept, the pointer moves to the non-winning requester (round-robin); its reset value selects requester 0.
REQ-018 Accept at edge N (req_valid[i] && req_ready[i]):
- opcode and operands of requester i register into operand registers;
- the winner index is stored;
- the FSM moves to EXEC.
REQ-019 EXEC, edge N+1: ALU output registers into resp_data; resp_err = (op > 9); the FSM moves to RESP.
REQ-020 RESP: resp_valid[winner] = 1 from cycle N+2; resp_data and resp_err are held stable until the handshake.
REQ-021 Response handshake: resp_valid[i] && resp_ready[i] at an edge returns the FSM to IDLE; the next accept happens no earlier than that following cycle.
REQ-022 Throughput: minimum 3 cycles per operation; accept-to-resp_valid latency is exactly 2 cycles.
REQ-023 resp_ready of the non-winning requester is ignored.
REQ-024 req_valid may drop without acceptance; no request is recorded unless it is accepted.
REQ-025 Illegal opcode (10-15): resp_data = 0 and resp_err = 1; the transaction otherwise completes normally.
REQ-026 Arithmetic is delegated to the ALU; shift amounts use b[4:0]; no saturation; the Zero flag is not used.

Reset
REQ-027 Asserting rst_n low forces, immediately and independently of clk:
- FSM to IDLE;
- priority pointer to requester 0;
- operand registers, resp_data and resp_err to 0;
- resp_valid to 0 and busy to 0.
REQ-028 Reset during EXEC or RESP abandons the in-flight operation; no response is ever issued for it.
REQ-029 Release of rst_n is treated synchronously; the first accept is possible at the first edge after release.

Structure
REQ-030 A shared package holds the opcode localparams (ADD=0 ... SLTU=9), OP_MAX=9, and the FSM state encoding.
REQ-031 The block instantiates exactly one sub-module, ALU, fed from the operand registers; it contains no other arithmetic.

Verification
REQ-032 Requester 0 only, op 0, a=5, b=7 -> req_ready[0] in IDLE; resp_valid[0] with resp_data=12 exactly 2 cycles after accept; resp_err=0.
REQ-033 Both requesters valid from reset (req0 op 1, a=10, b=3; req1 op 7, a=0x80000000, b=4):
- req0 is granted first and returns 7;
- req1 is granted next and returns 0xF8000000.
REQ-034 Both requesters valid continuously for 4 operations -> grants alternate 0,1,0,1; at most one req_ready bit and one resp_valid bit are set in any cycle.
REQ-035 resp_ready held low for 5 cycles in RESP:
- resp_valid and resp_data stay stable;
- busy=1 and req_ready=0 throughout;
- the FSM returns to IDLE one cycle after resp_ready rises.
REQ-036 Op 12, a=1, b=1 -> resp_data=0 and resp_err=1.
REQ-037 rst_n pulsed low in EXEC -> all outputs go to 0 without a clock edge; no resp_valid follows; the next request is granted to requester 0.
